aht_sensor_seq: RTL and testbench
=================================

AHT_SENSOR_SEQ -- requirements
Module: aht_sensor_seq

Interface
REQ-001 Parameter I2C_ADR, default 7'h38, 7-bit sensor slave address.
REQ-002 Parameter T_PWRUP, default 2_000_000, power-up wait in clk cycles.
REQ-003 Parameter T_MEAS, default 4_000_000, post-trigger wait in clk cycles.
REQ-004 Parameter T_PERIOD, default 50_000_000, idle gap between periodic measurements in clk cycles.
REQ-005 Parameter CRC_EN, default 1; 1 = read 7 bytes and check CRC, 0 = read 6 bytes with no check.
REQ-006 Parameter MAX_RETRY, default 3, number of re-measurements allowed after busy timeout or CRC failure.
REQ-007 Parameter BUSY_POLLS, default 8, number of status re-reads allowed while status bit 7 (busy) = 1.
REQ-008 Port clk, input, 1, system clock.
REQ-009 Port rst_n, input, 1; asynchronous, active-low reset.
REQ-010 Port mode, input, 1; 1 = periodic measurement, 0 = single-shot on trig.
REQ-011 Port trig, input, 1; single-cycle start pulse, honoured only in IDLE with mode = 0.
REQ-012 Port humi, output, 20, raw humidity.
REQ-013 Port temp, output, 20, raw temperature.
REQ-014 Port dout_vld, output, 1; one-cycle strobe when humi/temp update.
REQ-015 Port err, output, 1; one-cycle error strobe.
REQ-016 Port err_code, output, 2; 1 = nack, 2 = busy timeout, 3 = CRC; held until the next err strobe.
REQ-017 Port busy, output, 1; high in every state except IDLE.
REQ-018 Port req, output, 1; byte request to the I2C byte engine.
REQ-019 Port cmd, output, 4; cmd[0] = START, cmd[1] = WRITE, cmd[2] = READ, cmd[3] = STOP.
REQ-020 Port wr_data, output, 8, byte to transmit.
REQ-021 Port rd_data, input, 8, received byte, valid with done.
REQ-022 Port done, input, 1; one-cycle pulse marking completion of the current byte.
REQ-023 Port nack, input, 1; qualified by done, slave did not acknowledge.

Function
REQ-024 States: PWRUP, IDLE, STAT, INIT, MEAS, MWAIT, POLL, READ, CHECK, PERIOD.
REQ-025 Byte handshake: req, cmd and wr_data are held stable until done; the byte counter advances on done; req is low outside the byte-transfer states.
REQ-026 PWRUP: count T_PWRUP cycles, then go to IDLE.
REQ-027 IDLE: go to STAT when mode = 1, or when trig = 1 with mode = 0.
REQ-028 STAT sequence: {START|WRITE, addr+W}, {WRITE, 0x71}, {START|WRITE, addr+R}, {READ|STOP}.
  - Last-byte rd_data[3] = 0 -> INIT.
  - Last-byte rd_data[3] = 1 -> MEAS.
REQ-029 INIT sequence: addr+W, 0xE1, 0x08, then 0x00 with STOP; then -> STAT.
REQ-030 MEAS sequence: addr+W, 0xAC, 0x33, then 0x00 with STOP; then -> MWAIT.
REQ-031 MWAIT: count T_MEAS cycles, then -> POLL.
REQ-032 POLL: one-byte status read (START|WRITE addr+R, then READ|STOP).
  - bit7 = 0 -> READ.
  - bit7 = 1 -> wait T_MEAS/8 cycles and re-poll.
  - After BUSY_POLLS busy results -> busy-timeout handling.
REQ-033 READ: {START|WRITE, addr+R}, then N = 6+CRC_EN READ bytes, STOP on the last byte; all received bytes are captured into a shift buffer.
REQ-034 CHECK: CRC-8 over bytes 0..5 (poly 0x31, init 0xFF, MSB-first), compared against byte 6; CHECK lasts exactly 1 cycle when CRC_EN = 0.
REQ-035 CHECK pass:
  - humi = {b1, b2, b3[7:4]}.
  - temp = {b3[3:0], b4, b5}.
  - dout_vld pulses on the cycle humi/temp change.
  - retry counter clears.
  - -> PERIOD when mode = 1, else -> IDLE.
REQ-036 CRC fail or busy timeout with retry counter < MAX_RETRY: increment the counter and go to MEAS; humi/temp are not updated.
REQ-037 Retries exhausted: err pulses 1 cycle, err_code is set, the retry counter clears, then -> PERIOD/IDLE per mode.
REQ-038 nack = 1 with done in any byte state:
  - Abort the sequence; the next byte carries no STOP.
  - err pulses with err_code = 1.
  - -> IDLE; no retry.
  - The I2C engine is responsible for issuing STOP.
REQ-039 PERIOD: count T_PERIOD cycles, then -> IDLE; if mode = 0 in IDLE, the controller waits for trig.
REQ-040 trig is ignored outside IDLE; a mode change takes effect only at the next IDLE.
REQ-041 Timer widths are sized by $clog2 of the largest wait parameter; counters clear on every state entry.

Reset
REQ-042 Asynchronous assertion of rst_n forces state PWRUP, all counters 0, humi/temp 0, err_code 0, and req/dout_vld/err 0; this applies mid-transaction too, with no STOP issued.
REQ-043 Deassertion restarts the full T_PWRUP wait.

Verification
REQ-044 Scenario, normal single-shot:
  - Stimulus: status 0x18; trig; read bytes 1C 6B 3A 55 E1 27 plus model CRC.
  - Required: exact cmd/wr_data sequence; humi = 0x6B3A5, temp = 0x5E127; one dout_vld pulse.
REQ-045 Scenario, uncalibrated: status 0x10 -> INIT bytes 70 E1 08 00 with STOP on the last byte, then STAT repeats.
REQ-046 Scenario, busy polling: poll status 0x98 three times then 0x18 -> READ with no err; poll 0x98 BUSY_POLLS times -> MEAS retry.
REQ-047 Scenario, CRC: corrupt the CRC 4 consecutive times -> 3 retries, then err with err_code = 3, humi/temp unchanged; a correct CRC on retry 2 -> dout_vld with no err.
REQ-048 Scenario, nack: nack on the address byte -> err with err_code = 2'b01, IDLE, req low the following cycle.
REQ-049 Scenario, periodic and reset:
  - mode = 1: successive dout_vld pulses are spaced by T_PERIOD plus transaction time (use small parameters).
  - rst_n low mid-READ: outputs clear immediately and PWRUP restarts.

Source files
------------

// File: rtl/aht_sensor_seq.sv
// rtl/aht_sensor_seq.sv - AHT-series humidity/temperature sensor sequencer over an I2C byte engine
// Power-up wait, calibration check, trigger, busy polling, read-out with CRC check and retries.
module aht_sensor_seq #(
  parameter logic [6:0] I2C_ADR    = 7'h38,
  parameter int         T_PWRUP    = 2_000_000,
  parameter int         T_MEAS     = 4_000_000,
  parameter int         T_PERIOD   = 50_000_000,
  parameter int         CRC_EN     = 1,
  parameter int         MAX_RETRY  = 3,
  parameter int         BUSY_POLLS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic        trig,
  output logic [19:0] humi,
  output logic [19:0] temp,
  output logic        dout_vld,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic        req,
  output logic [3:0]  cmd,
  output logic [7:0]  wr_data,
  input  logic [7:0]  rd_data,
  input  logic        done,
  input  logic        nack
);

  localparam int T_POLL  = (T_MEAS / 8 > 0) ? T_MEAS / 8 : 1;
  localparam int T_MAX_A = (T_PWRUP > T_MEAS) ? T_PWRUP : T_MEAS;
  localparam int T_MAX   = (T_MAX_A > T_PERIOD) ? T_MAX_A : T_PERIOD;
  localparam int TW      = $clog2(T_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRY + 2);
  localparam int PW      = $clog2(BUSY_POLLS + 2);
  localparam int NB      = 6 + ((CRC_EN != 0) ? 1 : 0);

  localparam logic [TW-1:0] PWRUP_END  = TW'(T_PWRUP - 1);
  localparam logic [TW-1:0] MEAS_END   = TW'(T_MEAS - 1);
  localparam logic [TW-1:0] POLL_END   = TW'(T_POLL - 1);
  localparam logic [TW-1:0] PERIOD_END = TW'(T_PERIOD - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [PW-1:0] POLL_LAST  = PW'(BUSY_POLLS - 1);
  localparam logic [2:0]    RD_LAST    = 3'(NB);
  localparam logic [7:0]    ADR_W      = {I2C_ADR, 1'b0};
  localparam logic [7:0]    ADR_R      = {I2C_ADR, 1'b1};
  localparam logic [3:0]    C_S = 4'h1, C_W = 4'h2, C_R = 4'h4, C_P = 4'h8;

  typedef enum logic [3:0] {
    PWRUP, IDLE, STAT, INIT, MEAS, MWAIT, POLL, READ, CHECK, PERIOD
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [2:0]      idx, last_idx;
  logic [RW-1:0]   retry;
  logic [PW-1:0]   polls;
  logic            poll_wait, run_mode;
  logic [55:0]     sbuf;
  logic [7:0]      crc;
  logic            byte_end, crc_ok, fail, poll_start, poll_end;
  logic            do_vld, do_err, retry_inc, retry_clr;
  logic [1:0]      fail_code, code_nxt;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h31) : {r[6:0], 1'b0};
    return r;
  endfunction

  assign busy   = (state != IDLE);
  assign crc_ok = (CRC_EN == 0) || (crc == sbuf[7:0]);

  always_comb begin
    state_nxt  = state;
    req        = 1'b0;
    cmd        = 4'h0;
    wr_data    = 8'h00;
    last_idx   = 3'd3;
    fail       = 1'b0;
    fail_code  = 2'd0;
    poll_start = 1'b0;
    poll_end   = 1'b0;
    do_vld     = 1'b0;
    do_err     = 1'b0;
    code_nxt   = 2'd0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;

    // Byte table: what the engine is asked to do for the current byte.
    case (state)
      STAT: begin
        req = 1'b1;
        case (idx)
          3'd0:    begin cmd = C_S | C_W; wr_data = ADR_W; end
          3'd1:    begin cmd = C_W;       wr_data = 8'h71; end
          3'd2:    begin cmd = C_S | C_W; wr_data = ADR_R; end
          default: cmd = C_R | C_P;
        endcase
      end
      INIT, MEAS: begin
        req = 1'b1;
        case (idx)
          3'd0:    begin cmd = C_S | C_W; wr_data = ADR_W; end
          3'd1:    begin cmd = C_W; wr_data = (state == INIT) ? 8'hE1 : 8'hAC; end
          3'd2:    begin cmd = C_W; wr_data = (state == INIT) ? 8'h08 : 8'h33; end
          default: begin cmd = C_W | C_P; wr_data = 8'h00; end
        endcase
      end
      POLL: begin
        req      = !poll_wait;
        last_idx = 3'd1;
        if (idx == 3'd0) begin cmd = C_S | C_W; wr_data = ADR_R; end
        else cmd = C_R | C_P;
      end
      READ: begin
        req      = 1'b1;
        last_idx = RD_LAST;
        if (idx == 3'd0) begin cmd = C_S | C_W; wr_data = ADR_R; end
        else cmd = (idx == RD_LAST) ? (C_R | C_P) : C_R;
      end
      default: ;
    endcase

    byte_end = req && done && !nack && (idx == last_idx);

    if (req && done && nack) begin
      state_nxt = IDLE;
      do_err    = 1'b1;
      code_nxt  = 2'd1;
    end else begin
      case (state)
        PWRUP:  if (timer == PWRUP_END) state_nxt = IDLE;
        IDLE:   if (mode || trig) state_nxt = STAT;
        STAT:   if (byte_end) state_nxt = rd_data[3] ? MEAS : INIT;
        INIT:   if (byte_end) state_nxt = STAT;
        MEAS:   if (byte_end) state_nxt = MWAIT;
        MWAIT:  if (timer == MEAS_END) state_nxt = POLL;
        POLL: begin
          if (poll_wait) begin
            if (timer == POLL_END) poll_end = 1'b1;
          end else if (byte_end) begin
            if (!rd_data[7])              state_nxt = READ;
            else if (polls == POLL_LAST) begin fail = 1'b1; fail_code = 2'd2; end
            else                          poll_start = 1'b1;
          end
        end
        READ:   if (byte_end) state_nxt = CHECK;
        CHECK: begin
          if (crc_ok) begin
            do_vld    = 1'b1;
            retry_clr = 1'b1;
            state_nxt = run_mode ? PERIOD : IDLE;
          end else begin
            fail      = 1'b1;
            fail_code = 2'd3;
          end
        end
        PERIOD: if (timer == PERIOD_END) state_nxt = IDLE;
        default: state_nxt = PWRUP;
      endcase
    end

    // Busy timeout and CRC failure share the retry budget.
    if (fail) begin
      if (retry < RETRY_MAX) begin
        retry_inc = 1'b1;
        state_nxt = MEAS;
      end else begin
        do_err    = 1'b1;
        code_nxt  = fail_code;
        retry_clr = 1'b1;
        state_nxt = run_mode ? PERIOD : IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWRUP;
      timer     <= '0;
      idx       <= '0;
      retry     <= '0;
      polls     <= '0;
      poll_wait <= 1'b0;
      run_mode  <= 1'b0;
      sbuf      <= '0;
      crc       <= 8'hFF;
      humi      <= '0;
      temp      <= '0;
      dout_vld  <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || poll_start || poll_end) begin
        timer <= '0;
        idx   <= '0;
      end else begin
        timer <= timer + 1'b1;
        if (req && done) idx <= idx + 1'b1;
      end

      if (state_nxt != state) begin
        poll_wait <= 1'b0;
        polls     <= '0;
      end else if (poll_start) begin
        poll_wait <= 1'b1;
        polls     <= polls + 1'b1;
      end else if (poll_end) begin
        poll_wait <= 1'b0;
      end

      if (state == IDLE || retry_clr) retry <= '0;
      else if (retry_inc)             retry <= retry + 1'b1;

      if (state == IDLE) run_mode <= mode;

      // Data bytes 0..5 feed the CRC; byte 6 (if read) is the received CRC.
      if (state != READ) begin
        crc <= 8'hFF;
      end else if (req && done && !nack && idx != 3'd0) begin
        sbuf <= {sbuf[47:0], rd_data};
        if (idx <= 3'd6) crc <= crc8_step(crc, rd_data);
      end

      dout_vld <= do_vld;
      err      <= do_err;
      if (do_err) err_code <= code_nxt;
      if (do_vld) begin
        humi <= {sbuf[8*(NB-2) +: 8], sbuf[8*(NB-3) +: 8], sbuf[8*(NB-4)+4 +: 4]};
        temp <= {sbuf[8*(NB-4) +: 4], sbuf[8*(NB-5) +: 8], sbuf[8*(NB-6) +: 8]};
      end
    end
  end

endmodule

// File: tb/tb_aht_sensor_seq.sv
// tb/tb_aht_sensor_seq.sv - directed self-checking bench for aht_sensor_seq with a behavioural byte engine
module tb_aht_sensor_seq;

  localparam int T_PWRUP    = 20;
  localparam int T_MEAS     = 16;
  localparam int T_PERIOD   = 40;
  localparam int BUSY_POLLS = 4;

  localparam logic [11:0] EXP_SINGLE [0:17] = '{
    12'h370, 12'h271, 12'h371, 12'hC00,
    12'h370, 12'h2AC, 12'h233, 12'hA00,
    12'h371, 12'hC00,
    12'h371, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'hC00};
  localparam logic [11:0] EXP_INIT [0:3] = '{12'h370, 12'h2E1, 12'h208, 12'hA00};

  logic        clk = 1'b0, rst_n = 1'b0, mode = 1'b0, trig = 1'b0;
  logic [19:0] humi, temp;
  logic        dout_vld, err, busy, req;
  logic [1:0]  err_code;
  logic [3:0]  cmd;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data = 8'h00;
  logic        done = 1'b0, nack = 1'b0;

  int          checks = 0, passes = 0;
  int          vld_cnt = 0, err_cnt = 0, cyc = 0, nack_at = -1;
  logic [1:0]  err_last = 2'd0;
  logic [7:0]  rdq [$];
  logic [11:0] log_q [$];

  aht_sensor_seq #(
    .I2C_ADR(7'h38), .T_PWRUP(T_PWRUP), .T_MEAS(T_MEAS), .T_PERIOD(T_PERIOD),
    .CRC_EN(1), .MAX_RETRY(3), .BUSY_POLLS(BUSY_POLLS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .trig(trig),
    .humi(humi), .temp(temp), .dout_vld(dout_vld), .err(err), .err_code(err_code),
    .busy(busy), .req(req), .cmd(cmd), .wr_data(wr_data),
    .rd_data(rd_data), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Byte engine: completes each requested byte two cycles after it is seen.
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      nack = 1'b0;
      if (!rst_n) lat = 0;
      else if (req) begin
        lat++;
        if (lat == 2) begin
          lat = 0;
          if (nack_at == log_q.size()) nack = 1'b1;
          log_q.push_back({cmd, wr_data});
          if (cmd[2]) begin
            if (rdq.size() > 0) rd_data = rdq.pop_front();
            else rd_data = 8'h00;
          end
          done = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (dout_vld) vld_cnt++;
    if (err) begin
      err_cnt++;
      err_last = err_code;
    end
  end

  function automatic logic [7:0] model_crc(input logic [47:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    for (int i = 47; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
    end
    return c;
  endfunction

  task automatic push_frame(input logic [47:0] d, input logic good);
    logic [7:0] c;
    c = model_crc(d);
    if (!good) c = ~c;
    for (int i = 5; i >= 0; i--) rdq.push_back(d[8*i +: 8]);
    rdq.push_back(c);
  endtask

  task automatic prep();
    log_q.delete();
    rdq.delete();
    vld_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic pulse_trig();
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL %s_idle busy=%b after %0d cycles, want 0", nm, busy, n); else passes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL rst_busy got %b want 1", busy); else passes++;
    checks++; if (req !== 1'b0) $display("FAIL rst_req got %b want 0", req); else passes++;
    checks++; if ({dout_vld, err} !== 2'b00) $display("FAIL rst_strobes got %b want 00", {dout_vld, err}); else passes++;
    checks++; if ({humi, temp} !== 40'h0) $display("FAIL rst_data got %h want 0", {humi, temp}); else passes++;
    checks++; if (err_code !== 2'd0) $display("FAIL rst_err_code got %0d want 0", err_code); else passes++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL pwrup_busy got %b want 1", busy); else passes++;
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL pwrup_done busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_single();
    prep();
    rdq.push_back(8'h18);
    rdq.push_back(8'h18);
    push_frame(48'h1C6B3A55E127, 1'b1);
    pulse_trig();
    wait_idle("single", 2000);
    checks++; if (log_q.size() !== 18) $display("FAIL single_len got %0d want 18", log_q.size()); else passes++;
    for (int i = 0; i < 18 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== EXP_SINGLE[i]) $display("FAIL single_byte%0d got %h want %h", i, log_q[i], EXP_SINGLE[i]); else passes++;
    end
    checks++; if (humi !== 20'h6B3A5) $display("FAIL single_humi got %h want 6b3a5", humi); else passes++;
    checks++; if (temp !== 20'h5E127) $display("FAIL single_temp got %h want 5e127", temp); else passes++;
    checks++; if (vld_cnt !== 1) $display("FAIL single_vld got %0d want 1", vld_cnt); else passes++;
    checks++; if (err_cnt !== 0) $display("FAIL single_err got %0d want 0", err_cnt); else passes++;
  endtask

  task automatic test_uncal();
    prep();
    rdq.push_back(8'h10);
    rdq.push_back(8'h18);
    rdq.push_back(8'h18);
    push_frame(48'h1C123456789A, 1'b1);
    pulse_trig();
    wait_idle("uncal", 2000);
    checks++; if (log_q.size() !== 26) $display("FAIL uncal_len got %0d want 26", log_q.size()); else passes++;
    for (int i = 0; i < 4 && log_q.size() >= 12; i++) begin
      checks++; if (log_q[4+i] !== EXP_INIT[i]) $display("FAIL uncal_init%0d got %h want %h", i, log_q[4+i], EXP_INIT[i]); else passes++;
      checks++; if (log_q[8+i] !== EXP_SINGLE[i]) $display("FAIL uncal_stat%0d got %h want %h", i, log_q[8+i], EXP_SINGLE[i]); else passes++;
    end
    checks++; if ({humi, temp} !== 40'h123456789A) $display("FAIL uncal_data got %h want 123456789a", {humi, temp}); else passes++;
    checks++; if (vld_cnt !== 1) $display("FAIL uncal_vld got %0d want 1", vld_cnt); else passes++;
  endtask

  task automatic test_busy_poll();
    prep();
    rdq.push_back(8'h18);
    repeat (3) rdq.push_back(8'h98);
    rdq.push_back(8'h18);
    push_frame(48'h1C6B3A55E127, 1'b1);
    pulse_trig();
    wait_idle("busy_a", 2000);
    checks++; if (log_q.size() !== 24) $display("FAIL busy_a_len got %0d want 24", log_q.size()); else passes++;
    checks++; if ({vld_cnt, err_cnt} !== {32'd1, 32'd0}) $display("FAIL busy_a_strobes vld=%0d err=%0d want 1 0", vld_cnt, err_cnt); else passes++;

    prep();
    rdq.push_back(8'h18);
    repeat (BUSY_POLLS) rdq.push_back(8'h98);
    rdq.push_back(8'h18);
    push_frame(48'h1C6B3A55E127, 1'b1);
    pulse_trig();
    wait_idle("busy_b", 3000);
    checks++; if (log_q.size() !== 30) $display("FAIL busy_b_len got %0d want 30", log_q.size()); else passes++;
    if (log_q.size() >= 18) begin
      checks++; if ({log_q[16], log_q[17]} !== {12'h370, 12'h2AC}) $display("FAIL busy_b_remeas got %h %h want 370 2ac", log_q[16], log_q[17]); else passes++;
    end
    checks++; if ({vld_cnt, err_cnt} !== {32'd1, 32'd0}) $display("FAIL busy_b_strobes vld=%0d err=%0d want 1 0", vld_cnt, err_cnt); else passes++;
    checks++; if (humi !== 20'h6B3A5) $display("FAIL busy_b_humi got %h want 6b3a5", humi); else passes++;
  endtask

  task automatic test_crc();
    prep();
    rdq.push_back(8'h18);
    repeat (4) begin
      rdq.push_back(8'h18);
      push_frame(48'h1CAABBCCDDEE, 1'b0);
    end
    pulse_trig();
    wait_idle("crc_fail", 4000);
    checks++; if (log_q.size() !== 60) $display("FAIL crc_fail_len got %0d want 60", log_q.size()); else passes++;
    checks++; if (err_cnt !== 1) $display("FAIL crc_fail_err got %0d want 1", err_cnt); else passes++;
    checks++; if (err_last !== 2'd3) $display("FAIL crc_fail_code got %0d want 3", err_last); else passes++;
    checks++; if (vld_cnt !== 0) $display("FAIL crc_fail_vld got %0d want 0", vld_cnt); else passes++;
    checks++; if ({humi, temp} !== 40'h6B3A55E127) $display("FAIL crc_fail_data got %h want 6b3a55e127", {humi, temp}); else passes++;

    prep();
    rdq.push_back(8'h18);
    repeat (2) begin
      rdq.push_back(8'h18);
      push_frame(48'h1CAABBCCDDEE, 1'b0);
    end
    rdq.push_back(8'h18);
    push_frame(48'h1C0FEDCBA987, 1'b1);
    pulse_trig();
    wait_idle("crc_retry", 4000);
    checks++; if (log_q.size() !== 46) $display("FAIL crc_retry_len got %0d want 46", log_q.size()); else passes++;
    checks++; if ({vld_cnt, err_cnt} !== {32'd1, 32'd0}) $display("FAIL crc_retry_strobes vld=%0d err=%0d want 1 0", vld_cnt, err_cnt); else passes++;
    checks++; if ({humi, temp} !== 40'h0FEDCBA987) $display("FAIL crc_retry_data got %h want 0fedcba987", {humi, temp}); else passes++;
  endtask

  task automatic test_nack();
    int n;
    prep();
    nack_at = 0;
    pulse_trig();
    n = 0;
    while (!err && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (err !== 1'b1) $display("FAIL nack_err got %b want 1", err); else passes++;
    checks++; if (err_code !== 2'd1) $display("FAIL nack_code got %0d want 1", err_code); else passes++;
    checks++; if ({busy, req} !== 2'b00) $display("FAIL nack_idle busy/req got %b want 00", {busy, req}); else passes++;
    @(negedge clk);
    checks++; if ({req, err} !== 2'b00) $display("FAIL nack_after req/err got %b want 00", {req, err}); else passes++;
    nack_at = -1;
    repeat (3) @(negedge clk);
    checks++; if (log_q.size() !== 1) $display("FAIL nack_len got %0d want 1", log_q.size()); else passes++;
    checks++; if (err_cnt !== 1) $display("FAIL nack_err_cnt got %0d want 1", err_cnt); else passes++;
  endtask

  task automatic test_periodic();
    int vt [$];
    int n, gap;
    prep();
    repeat (2) begin
      rdq.push_back(8'h18);
      rdq.push_back(8'h18);
      push_frame(48'h1C6B3A55E127, 1'b1);
    end
    @(negedge clk);
    mode = 1'b1;
    n = 0;
    while (vt.size() < 2 && n < 1000) begin
      @(negedge clk);
      n++;
      if (dout_vld) vt.push_back(cyc);
    end
    mode = 1'b0;
    gap = (vt.size() == 2) ? vt[1] - vt[0] : -1;
    checks++; if (vt.size() !== 2) $display("FAIL periodic_count got %0d want 2", vt.size()); else passes++;
    checks++; if (gap !== 94) $display("FAIL periodic_gap got %0d want 94", gap); else passes++;
    wait_idle("periodic", 200);
    checks++; if (err_cnt !== 0) $display("FAIL periodic_err got %0d want 0", err_cnt); else passes++;
    checks++; if (log_q.size() !== 36) $display("FAIL periodic_len got %0d want 36", log_q.size()); else passes++;
  endtask

  task automatic test_reset_mid();
    int n, len;
    prep();
    rdq.push_back(8'h18);
    rdq.push_back(8'h18);
    push_frame(48'h1C123456789A, 1'b1);
    pulse_trig();
    n = 0;
    while (log_q.size() < 12 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++; if (log_q.size() < 12) $display("FAIL mid_reach got %0d bytes want 12", log_q.size()); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({req, dout_vld, err} !== 3'b000) $display("FAIL mid_strobes got %b want 000", {req, dout_vld, err}); else passes++;
    checks++; if ({humi, temp} !== 40'h0) $display("FAIL mid_data got %h want 0", {humi, temp}); else passes++;
    checks++; if (err_code !== 2'd0) $display("FAIL mid_code got %0d want 0", err_code); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else passes++;
    len = log_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if ({busy, req} !== 2'b10) $display("FAIL mid_pwrup busy/req got %b want 10", {busy, req}); else passes++;
    checks++; if (log_q.size() !== len) $display("FAIL mid_no_stop got %0d bytes want %0d", log_q.size(), len); else passes++;
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL mid_restart busy got %b want 0", busy); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_uncal();
    test_busy_poll();
    test_crc();
    test_nack();
    test_periodic();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
